// File: rtl/tbird_light_sequencer.sv
// -----------------------------------------------------------------------------
// tbird_light_sequencer
//
// Tail-lamp sequencer for a 3+3 lamp arrangement. Left and right turn requests
// (and both together for hazard) start a fixed lamp sequence. Each lamp step
// is paced by an internal prescaler, so every non-idle state lasts exactly
// TICK_DIV clock cycles. Once a sequence starts it always runs to completion.
// Requests are sampled only in IDLE.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   reset      synchronous, active-high reset (returns to IDLE, count 0)
//   Left       left turn request, level-sensitive
//   Right      right turn request, level-sensitive
//   y          lamp drive {LC,LB,LA,RA,RB,RC}, 1 = lamp on
//   busy       1 in every state other than IDLE
//   step_tick  1 on the last cycle of each lamp step (debug strobe)
// -----------------------------------------------------------------------------
module tbird_light_sequencer #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Left,
    input  logic       Right,
    output logic [5:0] y,
    output logic       busy,
    output logic       step_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        L1   = 4'd1,
        L2   = 4'd2,
        L3   = 4'd3,
        R1   = 4'd4,
        R2   = 4'd5,
        R3   = 4'd6,
        HAZ  = 4'd7,
        REST = 4'd8
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    // State register and prescaler count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next-state, prescaler and Moore output decode.
    always_comb begin
        state_next = state;
        count_next = '0;
        y          = 6'b000_000;
        busy       = 1'b0;
        step_tick  = 1'b0;

        case (state)
            IDLE: begin
                // Both switches together always win as hazard.
                if (Left && Right) begin
                    state_next = HAZ;
                end else if (Left) begin
                    state_next = L1;
                end else if (Right) begin
                    state_next = R1;
                end else begin
                    state_next = IDLE;
                end
            end

            L1, L2, L3, R1, R2, R3, HAZ, REST: begin
                busy       = 1'b1;
                step_tick  = (count == LAST);
                count_next = step_tick ? '0 : count + CW'(1);

                case (state)
                    L1:      y = 6'b001_000;
                    L2:      y = 6'b011_000;
                    L3:      y = 6'b111_000;
                    R1:      y = 6'b000_100;
                    R2:      y = 6'b000_110;
                    R3:      y = 6'b000_111;
                    HAZ:     y = 6'b111_111;
                    default: y = 6'b000_000;
                endcase

                if (step_tick) begin
                    case (state)
                        L1:      state_next = L2;
                        L2:      state_next = L3;
                        L3:      state_next = REST;
                        R1:      state_next = R2;
                        R2:      state_next = R3;
                        R3:      state_next = REST;
                        HAZ:     state_next = REST;
                        default: state_next = IDLE;
                    endcase
                end
            end

            // Unused encodings recover to IDLE on the next edge.
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tbird_light_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tbird_light_sequencer
//
// Bench for tbird_light_sequencer. A reference model keeps a queue of the lamp
// patterns still to be shown plus the cycles left in the current one; every
// cycle its expectation is compared with the DUT outputs. Directed scenarios
// also check hand-computed literal values at chosen cycles.
// -----------------------------------------------------------------------------
module tb_tbird_light_sequencer;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       Left = 1'b0;
    logic       Right = 1'b0;
    logic [5:0] y;
    logic       busy;
    logic       step_tick;

    int n_cmp = 0;
    int n_bad = 0;

    tbird_light_sequencer #(.TICK_DIV(TICK_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .Left      (Left),
        .Right     (Right),
        .y         (y),
        .busy      (busy),
        .step_tick (step_tick)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Queue of patterns still to show; the front is on the lamps now.
    logic [5:0] mq[$];
    int         rem = 0;
    bit         model_ok = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            rem = 0;
            model_ok = 1'b1;
        end else if (mq.size() == 0) begin
            if (Left && Right) begin
                mq.push_back(6'b111_111);
                mq.push_back(6'b000_000);
            end else if (Left) begin
                mq.push_back(6'b001_000);
                mq.push_back(6'b011_000);
                mq.push_back(6'b111_000);
                mq.push_back(6'b000_000);
            end else if (Right) begin
                mq.push_back(6'b000_100);
                mq.push_back(6'b000_110);
                mq.push_back(6'b000_111);
                mq.push_back(6'b000_000);
            end
            rem = TICK_DIV;
        end else begin
            rem = rem - 1;
            if (rem == 0) begin
                void'(mq.pop_front());
                rem = TICK_DIV;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [5:0] ey;
        logic       eb;
        logic       et;
        if (model_ok) begin
            ey = (mq.size() > 0) ? mq[0] : 6'b000_000;
            eb = (mq.size() > 0);
            et = (mq.size() > 0) && (rem == 1);
            n_cmp = n_cmp + 3;
            if (y !== ey) begin
                n_bad = n_bad + 1;
                $display("FAIL model_y t=%0t got=%b exp=%b", $time, y, ey);
            end
            if (busy !== eb) begin
                n_bad = n_bad + 1;
                $display("FAIL model_busy t=%0t got=%b exp=%b", $time, busy, eb);
            end
            if (step_tick !== et) begin
                n_bad = n_bad + 1;
                $display("FAIL model_tick t=%0t got=%b exp=%b", $time, step_tick, et);
            end
        end
    end

    // ---------------- driver / literal check tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s t=%0t got=%b exp=%b", name, $time, act, exp);
        end
    endtask

    // Pack {busy, step_tick, y} for compact literal checks.
    function automatic logic [7:0] outs();
        return {busy, step_tick, y};
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #20000;
        $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
        n_bad = n_bad + 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        // 1: reset for two cycles, then idle.
        cyc(2);
        reset = 1'b0;
        cyc(1);
        chk("reset_idle", outs(), 8'b00_000000);
        cyc(8);
        chk("idle_hold", outs(), 8'b00_000000);

        // 2: Left held. Set here, sampled at edge k; next negedge is cycle k+1.
        Left = 1'b1;
        cyc(1);  chk("l1_k1", outs(), 8'b10_001000);
        cyc(2);  chk("l1_k3_notick", outs(), 8'b10_001000);
        cyc(1);  chk("l1_k4_tick", outs(), 8'b11_001000);
        cyc(1);  chk("l2_k5", outs(), 8'b10_011000);
        cyc(3);  chk("l2_k8_tick", outs(), 8'b11_011000);
        cyc(1);  chk("l3_k9", outs(), 8'b10_111000);
        cyc(3);  chk("l3_k12_tick", outs(), 8'b11_111000);
        cyc(1);  chk("rest_k13", outs(), 8'b10_000000);
        cyc(3);  chk("rest_k16_tick", outs(), 8'b11_000000);
        cyc(1);  chk("idle_k17", outs(), 8'b00_000000);
        cyc(1);  chk("l1_again_k18", outs(), 8'b10_001000);
        Left = 1'b0;
        cyc(20);
        chk("drain_left", outs(), 8'b00_000000);

        // 3: Right one-cycle pulse.
        Right = 1'b1;
        cyc(1);  Right = 1'b0;
        chk("r1_k1", outs(), 8'b10_000100);
        cyc(4);  chk("r2_k5", outs(), 8'b10_000110);
        cyc(4);  chk("r3_k9", outs(), 8'b10_000111);
        cyc(3);  chk("r3_k12_tick", outs(), 8'b11_000111);
        cyc(1);  chk("rest_r_k13", outs(), 8'b10_000000);
        cyc(4);  chk("idle_r_k17", outs(), 8'b00_000000);
        cyc(3);

        // 4: both on the same edge -> hazard.
        Left = 1'b1;
        Right = 1'b1;
        cyc(1);  Left = 1'b0; Right = 1'b0;
        chk("haz_k1", outs(), 8'b10_111111);
        cyc(3);  chk("haz_k4_tick", outs(), 8'b11_111111);
        cyc(1);  chk("haz_rest_k5", outs(), 8'b10_000000);
        cyc(4);  chk("haz_idle_k9", outs(), 8'b00_000000);
        cyc(3);

        // 5: Left sequence, switch to Right during L2.
        Left = 1'b1;
        cyc(5);  chk("sw_l2_k5", outs(), 8'b10_011000);
        Left = 1'b0;
        Right = 1'b1;
        cyc(4);  chk("sw_l3_k9", outs(), 8'b10_111000);
        cyc(4);  chk("sw_rest_k13", outs(), 8'b10_000000);
        cyc(4);  chk("sw_idle_k17", outs(), 8'b00_000000);
        cyc(1);  chk("sw_r1_k18", outs(), 8'b10_000100);
        Right = 1'b0;
        cyc(20);

        // 6: reset during L3, Left still held.
        Left = 1'b1;
        cyc(9);  chk("rst_l3_k9", outs(), 8'b10_111000);
        reset = 1'b1;
        cyc(1);  chk("rst_abort", outs(), 8'b00_000000);
        reset = 1'b0;
        cyc(1);  chk("rst_l1_start", outs(), 8'b10_001000);
        cyc(2);  chk("rst_l1_notick", outs(), 8'b10_001000);
        cyc(1);  chk("rst_l1_tick", outs(), 8'b11_001000);
        cyc(1);  chk("rst_l2", outs(), 8'b10_011000);
        Left = 1'b0;
        cyc(20);
        chk("final_idle", outs(), 8'b00_000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
